// File: rtl/fmac_issue_ctrl_if.sv
// Request, datapath and response signals of the FMA issue sequencer.
// The slave modport is the sequencer's view; the master modport is its environment's view.
interface fmac_issue_ctrl_if #(
    parameter int C_OP = 32
);
    logic            flush;
    logic            req_vld;
    logic            req_rdy;
    logic [3:0]      cmd;
    logic [1:0]      rm;
    logic [C_OP-1:0] op_a;
    logic [C_OP-1:0] op_b;
    logic [C_OP-1:0] op_c;
    logic            dp_start;
    logic            dp_kill;
    logic [C_OP-1:0] dp_a;
    logic [C_OP-1:0] dp_b;
    logic [C_OP-1:0] dp_c;
    logic [1:0]      dp_rm;
    logic [C_OP-1:0] dp_res_dat;
    logic [4:0]      dp_fflags;
    logic            rsp_vld;
    logic            rsp_rdy;
    logic [C_OP-1:0] rsp_dat;
    logic [4:0]      rsp_fflags;
    logic            busy;

    modport slave (
        input  flush, req_vld, cmd, rm, op_a, op_b, op_c, dp_res_dat, dp_fflags, rsp_rdy,
        output req_rdy, dp_start, dp_kill, dp_a, dp_b, dp_c, dp_rm, rsp_vld, rsp_dat,
               rsp_fflags, busy
    );

    modport master (
        output flush, req_vld, cmd, rm, op_a, op_b, op_c, dp_res_dat, dp_fflags, rsp_rdy,
        input  req_rdy, dp_start, dp_kill, dp_a, dp_b, dp_c, dp_rm, rsp_vld, rsp_dat,
               rsp_fflags, busy
    );
endinterface

// File: rtl/fmac_issue_ctrl.sv
// Single-op FMA sequencer: resolves NaN/Inf/zero locally (result 2 cycles after accept), else
// launches the datapath (C_LATENCY+2); req_rdy only in IDLE, result held until rsp_rdy.
module fmac_issue_ctrl #(
    parameter int C_OP      = 32,
    parameter int C_EXP     = 8,
    parameter int C_MANT    = 23,
    parameter int C_LATENCY = 3,
    parameter int C_CNT_W   = 4
) (
    input logic              clk,
    input logic              rst,
    fmac_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DECODE, EXEC, DONE} state_t;

    typedef struct packed {
        logic nan;
        logic snan;
        logic inf;
        logic zero;
    } fp_class_t;

    localparam int              SB      = C_OP - 1;
    localparam logic [C_OP-1:0] QNAN    = {1'b0, {C_EXP{1'b1}}, 1'b1, {(C_MANT-1){1'b0}}};
    localparam logic [4:0]      FLAG_NV = 5'b10000;

    function automatic fp_class_t classify(input logic [C_OP-1:0] x);
        fp_class_t k;
        logic      exp_ones;
        logic      exp_zero;
        logic      mant_zero;
        exp_ones  = &x[C_EXP+C_MANT-1 -: C_EXP];
        exp_zero  = ~|x[C_EXP+C_MANT-1 -: C_EXP];
        mant_zero = ~|x[C_MANT-1:0];
        k.nan     = exp_ones & ~mant_zero;
        k.snan    = exp_ones & ~mant_zero & ~x[C_MANT-1];
        k.inf     = exp_ones & mant_zero;
        k.zero    = exp_zero & mant_zero;
        return k;
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         cmd_q;
    logic [1:0]         rm_q;
    logic [C_OP-1:0]    a_q, b_q, c_q;
    logic [C_CNT_W-1:0] cnt_q;
    logic [C_OP-1:0]    res_q;
    logic [4:0]         ff_q;

    logic            accept, launch, kill, cap_spec, cap_dp, cnt_dec;
    fp_class_t       ca, cb, cc;
    logic            sp, sc, prod_inf, prod_zero, zsign;
    logic            is_special;
    logic [C_OP-1:0] spec_res;
    logic [4:0]      spec_ff;

    // Special-case resolution on the sign-adjusted latched operands, highest priority first.
    always_comb begin
        ca         = classify(a_q);
        cb         = classify(b_q);
        cc         = classify(c_q);
        sp         = a_q[SB] ^ b_q[SB];
        sc         = c_q[SB];
        prod_inf   = ca.inf | cb.inf;
        prod_zero  = ca.zero | cb.zero;
        zsign      = (sp == sc) ? sp : (rm_q == 2'd3);
        is_special = 1'b1;
        spec_res   = QNAN;
        spec_ff    = FLAG_NV;
        if (cmd_q[3:2] != 2'b10) begin
            spec_ff = FLAG_NV;
        end else if (ca.nan | cb.nan | cc.nan) begin
            spec_ff = (ca.snan | cb.snan | cc.snan) ? FLAG_NV : 5'b0;
        end else if ((ca.inf & cb.zero) | (ca.zero & cb.inf) | (prod_inf & cc.inf & (sp != sc))) begin
            spec_ff = FLAG_NV;
        end else if (prod_inf) begin
            spec_res = {sp, {C_EXP{1'b1}}, {C_MANT{1'b0}}};
            spec_ff  = 5'b0;
        end else if (cc.inf) begin
            spec_res = c_q;
            spec_ff  = 5'b0;
        end else if (prod_zero & cc.zero) begin
            spec_res = {zsign, {(C_OP-1){1'b0}}};
            spec_ff  = 5'b0;
        end else if (prod_zero) begin
            spec_res = c_q;
            spec_ff  = 5'b0;
        end else begin
            is_special = 1'b0;
            spec_res   = '0;
            spec_ff    = 5'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        launch   = 1'b0;
        kill     = 1'b0;
        cap_spec = 1'b0;
        cap_dp   = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_vld) begin
                    accept  = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (is_special) begin
                    cap_spec = 1'b1;
                    state_d  = DONE;
                end else begin
                    launch  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    cap_dp  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                if (bus.rsp_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Flush overrides everything; a launch in the same cycle is paired with a kill.
        if (bus.flush) begin
            kill     = launch | (state_q == EXEC);
            state_d  = IDLE;
            accept   = 1'b0;
            cap_spec = 1'b0;
            cap_dp   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q <= '0;
            rm_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            cnt_q <= '0;
            res_q <= '0;
            ff_q  <= '0;
        end else begin
            if (accept) begin
                cmd_q <= bus.cmd;
                rm_q  <= bus.rm;
                a_q   <= {bus.op_a[SB] ^ bus.cmd[1], bus.op_a[SB-1:0]};
                b_q   <= bus.op_b;
                c_q   <= {bus.op_c[SB] ^ bus.cmd[1] ^ bus.cmd[0], bus.op_c[SB-1:0]};
            end
            if (launch)       cnt_q <= C_CNT_W'(C_LATENCY - 1);
            else if (cnt_dec) cnt_q <= cnt_q - C_CNT_W'(1);
            if (cap_spec) begin
                res_q <= spec_res;
                ff_q  <= spec_ff;
            end else if (cap_dp) begin
                res_q <= bus.dp_res_dat;
                ff_q  <= bus.dp_fflags;
            end
        end
    end

    assign bus.req_rdy    = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.rsp_vld    = (state_q == DONE) & ~bus.flush;
    assign bus.rsp_dat    = res_q;
    assign bus.rsp_fflags = ff_q;
    assign bus.dp_start   = launch;
    assign bus.dp_kill    = kill;
    assign bus.dp_a       = a_q;
    assign bus.dp_b       = b_q;
    assign bus.dp_c       = c_q;
    assign bus.dp_rm      = rm_q;
endmodule

// File: tb/tb_fmac_issue_ctrl.sv
// Bench for fmac_issue_ctrl: vector table, randomized ops against a rule-level model,
// and hand-written backpressure / flush / reset sequences, with a latency-checking datapath stub.
module tb_fmac_issue_ctrl;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fmac_issue_ctrl_if #(.C_OP(32)) bus();

    fmac_issue_ctrl #(
        .C_OP(32), .C_EXP(8), .C_MANT(23), .C_LATENCY(LAT), .C_CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", name, got, exp);
        end
    endtask

    // Datapath stub: returns a recognisable value only in the cycle LAT cycles after dp_start.
    int age = 0;
    always @(negedge clk) begin
        if (rst || bus.dp_kill) age = 0;
        else if (bus.dp_start)  age = 1;
        else if (age != 0)      age = age + 1;
        if (age == LAT + 1) begin
            bus.dp_res_dat = bus.dp_a ^ bus.dp_b ^ bus.dp_c;
            bus.dp_fflags  = bus.dp_a[4:0] ^ 5'b00101;
        end else begin
            bus.dp_res_dat = 32'hDEADBEEF;
            bus.dp_fflags  = 5'b11111;
        end
    end

    typedef enum {K_NUM, K_ZERO, K_INF, K_QNAN, K_SNAN} kind_t;

    function automatic kind_t kind(input logic [31:0] x);
        logic [7:0]  e;
        logic [22:0] m;
        e = x[30:23];
        m = x[22:0];
        if (e == 8'hFF) begin
            if (m == 23'd0) return K_INF;
            return x[22] ? K_QNAN : K_SNAN;
        end
        if (e == 8'd0 && m == 23'd0) return K_ZERO;
        return K_NUM;
    endfunction

    task automatic model(input logic [3:0] cmd, input logic [1:0] rm,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         output logic spec, output logic [31:0] res, output logic [4:0] ff,
                         output logic [31:0] dpa, output logic [31:0] dpc);
        logic  neg_prod, neg_add, sp, sc, pinf, pzero, anynan, anysnan;
        kind_t ka, kb, kc;
        neg_prod = (cmd == 4'hA) || (cmd == 4'hB);
        neg_add  = (cmd == 4'h9) || (cmd == 4'hA);
        dpa = a ^ {neg_prod, 31'b0};
        dpc = c ^ {neg_add, 31'b0};
        ka = kind(dpa); kb = kind(b); kc = kind(dpc);
        sp = dpa[31] ^ b[31];
        sc = dpc[31];
        pinf    = (ka == K_INF) || (kb == K_INF);
        pzero   = (ka == K_ZERO) || (kb == K_ZERO);
        anynan  = (ka inside {K_QNAN, K_SNAN}) || (kb inside {K_QNAN, K_SNAN}) || (kc inside {K_QNAN, K_SNAN});
        anysnan = (ka == K_SNAN) || (kb == K_SNAN) || (kc == K_SNAN);
        spec = 1'b1;
        res  = 32'h7FC00000;
        ff   = 5'b0;
        if (!(cmd inside {[4'h8:4'hB]}))                     ff = 5'b10000;
        else if (anynan)                                    ff = anysnan ? 5'b10000 : 5'b0;
        else if ((pinf && pzero) || (pinf && kc == K_INF && sp != sc)) ff = 5'b10000;
        else if (pinf)                                      res = {sp, 8'hFF, 23'd0};
        else if (kc == K_INF)                               res = dpc;
        else if (pzero && kc == K_ZERO)                     res = (((sp == sc) ? sp : (rm == 2'd3)) ? 32'h80000000 : 32'h0);
        else if (pzero)                                     res = dpc;
        else begin
            spec = 1'b0;
            res  = dpa ^ b ^ dpc;
            ff   = dpa[4:0] ^ 5'b00101;
        end
    endtask

    // Issues one op from IDLE with rsp_rdy high; lat counts clock edges from the accept edge.
    task automatic do_op(input logic [3:0] cmd, input logic [1:0] rm,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         output logic [31:0] res, output logic [4:0] ff, output int lat,
                         output int starts, output logic [31:0] dpa, output logic [31:0] dpc,
                         output logic [1:0] dprm, output logic idle_after);
        bus.cmd = cmd; bus.rm = rm; bus.op_a = a; bus.op_b = b; bus.op_c = c;
        bus.rsp_rdy = 1'b1;
        bus.req_vld = 1'b1;
        @(posedge clk); #1;
        bus.req_vld = 1'b0;
        lat    = 1;
        starts = bus.dp_start ? 1 : 0;
        dpa = bus.dp_a; dpc = bus.dp_c; dprm = bus.dp_rm;
        while (!bus.rsp_vld && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus.dp_start) starts++;
        end
        res = bus.rsp_dat;
        ff  = bus.rsp_fflags;
        @(posedge clk); #1;
        idle_after = bus.req_rdy && !bus.rsp_vld;
    endtask

    task automatic run_check(input string tag, input logic [3:0] cmd, input logic [1:0] rm,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                             input logic [31:0] exp_res, input logic [4:0] exp_ff, input int exp_lat,
                             input bit chk_dp, input logic [31:0] exp_dpa, input logic [31:0] exp_dpc);
        logic [31:0] res, dpa, dpc;
        logic [4:0]  ff;
        logic [1:0]  dprm;
        logic        idle_after;
        int          lat, starts;
        do_op(cmd, rm, a, b, c, res, ff, lat, starts, dpa, dpc, dprm, idle_after);
        chk({tag, " result"}, res, exp_res);
        chk({tag, " fflags"}, 32'(ff), 32'(exp_ff));
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " dp_start count"}, 32'(starts), (exp_lat == LAT + 2) ? 32'd1 : 32'd0);
        chk({tag, " idle after transfer"}, 32'(idle_after), 32'd1);
        if (chk_dp) begin
            chk({tag, " dp_a"}, dpa, exp_dpa);
            chk({tag, " dp_c"}, dpc, exp_dpc);
            chk({tag, " dp_rm"}, 32'(dprm), 32'(rm));
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        logic        s;
        case ($urandom_range(0, 9))
            0:       v = 32'h00000000;
            1:       v = 32'h7F800000;
            2:       v = 32'h7FC00000 | ($urandom & 32'h003FFFFF);
            3:       v = 32'h7F800000 | ($urandom_range(1, 32'h003FFFFF));
            4:       v = 32'h3F800000;
            5:       v = $urandom & 32'h007FFFFF;
            default: v = $urandom;
        endcase
        s = 1'($urandom_range(0, 1));
        return v ^ {s, 31'b0};
    endfunction

    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  rm;
        logic [31:0] a, b, c;
        logic [31:0] res;
        logic [4:0]  ff;
        int          lat;
        bit          chk_dp;
        logic [31:0] dpa, dpc;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic        m_spec, seen;
        logic [31:0] m_res, m_dpa, m_dpc, ra, rb, rc;
        logic [4:0]  m_ff;
        logic [3:0]  rcmd;
        logic [1:0]  rrm;

        vecs[0]  = '{4'h8, 2'd0, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40000000, 5'b00101, 5, 1'b1, 32'h3F800000, 32'h3F800000};
        vecs[1]  = '{4'hB, 2'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'hBFC00000, 5'b00101, 5, 1'b1, 32'hBF800000, 32'h40400000};
        vecs[2]  = '{4'h9, 2'd1, 32'h3F800000, 32'h40000000, 32'h40400000, 32'hBFC00000, 5'b00101, 5, 1'b1, 32'h3F800000, 32'hC0400000};
        vecs[3]  = '{4'h8, 2'd0, 32'h7F800000, 32'h00000000, 32'h3F800000, 32'h7FC00000, 5'b10000, 2, 1'b1, 32'h7F800000, 32'h3F800000};
        vecs[4]  = '{4'h8, 2'd0, 32'h7F800001, 32'h3F800000, 32'h00000000, 32'h7FC00000, 5'b10000, 2, 1'b1, 32'h7F800001, 32'h00000000};
        vecs[5]  = '{4'h8, 2'd0, 32'h7FC00001, 32'h3F800000, 32'h00000000, 32'h7FC00000, 5'b00000, 2, 1'b1, 32'h7FC00001, 32'h00000000};
        vecs[6]  = '{4'h8, 2'd3, 32'h00000000, 32'h3F800000, 32'h80000000, 32'h80000000, 5'b00000, 2, 1'b1, 32'h00000000, 32'h80000000};
        vecs[7]  = '{4'h8, 2'd0, 32'h00000000, 32'h3F800000, 32'h80000000, 32'h00000000, 5'b00000, 2, 1'b1, 32'h00000000, 32'h80000000};
        vecs[8]  = '{4'h3, 2'd0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 5'b10000, 2, 1'b0, 32'h0, 32'h0};
        vecs[9]  = '{4'h9, 2'd0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 32'h7FC00000, 5'b10000, 2, 1'b1, 32'h7F800000, 32'hFF800000};
        vecs[10] = '{4'h8, 2'd0, 32'h7F800000, 32'hBF800000, 32'hFF800000, 32'hFF800000, 5'b00000, 2, 1'b1, 32'h7F800000, 32'hFF800000};
        vecs[11] = '{4'hA, 2'd0, 32'h3F800000, 32'h40000000, 32'h7F800000, 32'hFF800000, 5'b00000, 2, 1'b1, 32'hBF800000, 32'hFF800000};
        vecs[12] = '{4'h9, 2'd0, 32'h00000000, 32'h40000000, 32'h40400000, 32'hC0400000, 5'b00000, 2, 1'b1, 32'h00000000, 32'hC0400000};
        vecs[13] = '{4'hA, 2'd0, 32'h00000000, 32'h00000000, 32'h00000000, 32'h80000000, 5'b00000, 2, 1'b1, 32'h80000000, 32'h80000000};
        vecs[14] = '{4'h8, 2'd0, 32'h00000001, 32'h3F800000, 32'h00000000, 32'h3F800001, 5'b00100, 5, 1'b1, 32'h00000001, 32'h00000000};
        vecs[15] = '{4'h8, 2'd0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 5'b00000, 2, 1'b1, 32'h7F800000, 32'h7FC00000};
        vecs[16] = '{4'h8, 2'd2, 32'h40000000, 32'h40400000, 32'hBF800000, 32'hBFC00000, 5'b00101, 5, 1'b1, 32'h40000000, 32'hBF800000};

        bus.flush = 1'b0; bus.req_vld = 1'b0; bus.rsp_rdy = 1'b0;
        bus.cmd = 4'h0; bus.rm = 2'd0; bus.op_a = '0; bus.op_b = '0; bus.op_c = '0;

        #2;
        chk("reset req_rdy", 32'(bus.req_rdy), 32'd1);
        chk("reset rsp_vld", 32'(bus.rsp_vld), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset dp_start", 32'(bus.dp_start), 32'd0);
        chk("reset dp_kill", 32'(bus.dp_kill), 32'd0);
        chk("reset rsp_dat", bus.rsp_dat, 32'd0);
        chk("reset rsp_fflags", 32'(bus.rsp_fflags), 32'd0);
        chk("reset dp_a", bus.dp_a, 32'd0);
        chk("reset dp_c", bus.dp_c, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < $size(vecs); i++)
            run_check($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].rm, vecs[i].a, vecs[i].b, vecs[i].c,
                      vecs[i].res, vecs[i].ff, vecs[i].lat, vecs[i].chk_dp, vecs[i].dpa, vecs[i].dpc);

        for (int i = 0; i < 60; i++) begin
            rcmd = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(8, 11));
            rrm  = 2'($urandom_range(0, 3));
            ra = pick(); rb = pick(); rc = pick();
            model(rcmd, rrm, ra, rb, rc, m_spec, m_res, m_ff, m_dpa, m_dpc);
            run_check($sformatf("rand%0d", i), rcmd, rrm, ra, rb, rc, m_res, m_ff,
                      m_spec ? 2 : LAT + 2, rcmd inside {[4'h8:4'hB]}, m_dpa, m_dpc);
        end

        // Backpressure: result held while rsp_rdy is low; a request during the busy period is ignored.
        bus.rsp_rdy = 1'b0;
        bus.cmd = 4'h8; bus.rm = 2'd0; bus.op_a = 32'h7F800000; bus.op_b = 32'h0; bus.op_c = 32'h0;
        bus.req_vld = 1'b1;
        @(posedge clk); #1;
        bus.op_a = 32'h3F800000; bus.op_b = 32'h3F800000;
        @(posedge clk); #1;
        chk("bp valid rises", 32'(bus.rsp_vld), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d rsp_vld", k), 32'(bus.rsp_vld), 32'd1);
            chk($sformatf("bp%0d rsp_dat", k), bus.rsp_dat, 32'h7FC00000);
            chk($sformatf("bp%0d rsp_fflags", k), 32'(bus.rsp_fflags), 32'h10);
            chk($sformatf("bp%0d req_rdy", k), 32'(bus.req_rdy), 32'd0);
        end
        bus.req_vld = 1'b0;
        bus.rsp_rdy = 1'b1;
        @(posedge clk); #1;
        chk("bp after transfer rsp_vld", 32'(bus.rsp_vld), 32'd0);
        chk("bp after transfer req_rdy", 32'(bus.req_rdy), 32'd1);
        chk("bp busy request not latched", bus.dp_a, 32'h7F800000);

        // Flush in the second EXEC cycle.
        bus.cmd = 4'h8; bus.op_a = 32'h3F800000; bus.op_b = 32'h40000000; bus.op_c = 32'h3F800000;
        bus.req_vld = 1'b1;
        @(posedge clk); #1;
        bus.req_vld = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.flush = 1'b1;
        #1;
        chk("flush dp_kill", 32'(bus.dp_kill), 32'd1);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush idle req_rdy", 32'(bus.req_rdy), 32'd1);
        chk("flush idle busy", 32'(bus.busy), 32'd0);
        chk("flush kill one cycle", 32'(bus.dp_kill), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (bus.rsp_vld) seen = 1'b1;
        end
        chk("flush no result", 32'(seen), 32'd0);

        // Reset in the middle of EXEC.
        bus.op_a = 32'h40000000;
        bus.req_vld = 1'b1;
        @(posedge clk); #1;
        bus.req_vld = 1'b0;
        @(posedge clk); #1;
        chk("pre-reset busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst req_rdy", 32'(bus.req_rdy), 32'd1);
        chk("midrst rsp_dat", bus.rsp_dat, 32'd0);
        chk("midrst dp_a", bus.dp_a, 32'd0);
        chk("midrst rsp_vld", 32'(bus.rsp_vld), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Flush in IDLE coinciding with a request: the request is dropped.
        bus.op_a = 32'h7F800000; bus.op_b = 32'h0;
        bus.req_vld = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.req_vld = 1'b0;
        bus.flush = 1'b0;
        chk("idle flush busy", 32'(bus.busy), 32'd0);
        chk("idle flush dp_a", bus.dp_a, 32'd0);
        @(posedge clk); #1;
        chk("idle flush no result", 32'(bus.rsp_vld), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
